// File: rtl/pll_cal_pkg.sv
// pll_cal_pkg: shared types and helpers for the PLL coarse-calibration
// sequencer.
//   state_t  : sequencer states
//   dir_t    : direction of the last linear (+/-1) code move
//   code_mid : mid-scale DCO code, 2^(width-1)
//   code_max : full-scale DCO code, 2^width - 1
package pll_cal_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT      = 3'd2,
    ADJUST    = 3'd3,
    SETTLE    = 3'd4,
    DONE_OK   = 3'd5,
    DONE_FAIL = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } dir_t;

  function automatic int unsigned code_mid(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

  function automatic int unsigned code_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pll_cal_timer.sv
// pll_cal_timer: loadable down-counter with a one-cycle terminal-count pulse.
// A load of N makes tc pulse in the (N+1)-th cycle after the load, so a load
// of (len-1) marks the last cycle of a len-cycle interval.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : start a new interval (restarts any running one)
//   load_val  : interval length minus one
//   tc        : high for one cycle when the interval expires
module pll_cal_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          tc
);

  localparam logic [TW-1:0] ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] ONE  = TW'(1);

  logic [TW-1:0] cnt_r;
  logic          run_r;

  // Count down while running; stop after the terminal cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO;
      run_r <= 1'b0;
    end else if (load) begin
      cnt_r <= load_val;
      run_r <= 1'b1;
    end else if (run_r) begin
      if (cnt_r == ZERO) begin
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - ONE;
      end
    end
  end

  assign tc = run_r && (cnt_r == ZERO);

endmodule

// File: rtl/pll_cal_ctrl.sv
// pll_cal_ctrl: coarse DCO-code calibration sequencer driving a calibrating
// PFD. Re-arms the PFD, waits for its verdict, binary-searches the code, then
// walks it by +/-1 until the verdict flips (matched) or the PFD stays silent
// for a whole check window (locked).
// Optional build macro: PLL_CAL_ITER_CNT_EN adds the cal_iter output.
// Ports:
//   ref_clk, rst          : sole clock, synchronous active-high reset
//   cal_start             : start pulse, ignored unless idle
//   freq_check_done       : PFD verdict valid
//   ref_clk_is_faster/slower : PFD verdict flags (raise / lower the code)
//   pfd_rst_n             : registered active-low PFD reset, high only in WAIT
//   dco_code              : registered DCO tuning code
//   cal_busy              : calibration in progress
//   cal_locked, cal_fail  : sticky result flags, cleared on start/reset
//   cal_iter              : (optional) ADJUST count since start, saturating
module pll_cal_ctrl
  import pll_cal_pkg::*;
#(
  parameter int CODE_W        = 6,
  parameter int ARM_CYC       = 4,
  parameter int CHECK_TIMEOUT = 200,
  parameter int SETTLE_CYC    = 16,
  parameter int MAX_LIN       = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              cal_start,
  input  logic              freq_check_done,
  input  logic              ref_clk_is_faster,
  input  logic              ref_clk_is_slower,
  output logic              pfd_rst_n,
  output logic [CODE_W-1:0] dco_code,
  output logic              cal_busy,
  output logic              cal_locked,
  output logic              cal_fail
`ifdef PLL_CAL_ITER_CNT_EN
  ,
  output logic [7:0]        cal_iter
`endif
);

  localparam int TW = $clog2(CHECK_TIMEOUT + 1);
  localparam int LW = $clog2(MAX_LIN + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [CODE_W-1:0] MID   = CODE_W'(code_mid(CODE_W));
  localparam logic [CODE_W-1:0] MAXC  = CODE_W'(code_max(CODE_W));
  localparam logic [CODE_W-1:0] STEP0 = CODE_W'(code_mid(CODE_W - 1));
  localparam logic [CODE_W-1:0] ZC    = {CODE_W{1'b0}};
  localparam logic [CODE_W-1:0] ONEC  = CODE_W'(1);

  state_t            state_r, state_nxt;
  logic [CODE_W-1:0] code_nxt, step_r, step_nxt;
  logic [LW-1:0]     lin_r, lin_nxt, lin_inc_s;
  logic [RW-1:0]     retry_r, retry_nxt;
  dir_t              dir_r, dir_nxt, mv_dir_s;
  logic              fast_r, fast_nxt, slow_r, slow_nxt;
  logic              locked_nxt, fail_nxt;
  logic [CODE_W:0]   sum_s, dif_s;
  logic              tmr_load_s, tc_s;
  logic [TW-1:0]     tmr_val_s;

  pll_cal_timer #(.TW(TW)) u_timer (
    .clk      (ref_clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tc_s)
  );

  // Next-state and datapath decisions.
  always_comb begin
    state_nxt  = state_r;
    code_nxt   = dco_code;
    step_nxt   = step_r;
    lin_nxt    = lin_r;
    retry_nxt  = retry_r;
    dir_nxt    = dir_r;
    fast_nxt   = fast_r;
    slow_nxt   = slow_r;
    locked_nxt = cal_locked;
    fail_nxt   = cal_fail;
    // One extra bit catches overflow/underflow before clamping.
    sum_s      = {1'b0, dco_code} + {1'b0, step_r};
    dif_s      = {1'b0, dco_code} - {1'b0, step_r};
    lin_inc_s  = lin_r + LW'(1);
    mv_dir_s   = fast_r ? UP : DN;
    case (state_r)
      IDLE: begin
        if (cal_start) begin
          state_nxt  = ARM;
          code_nxt   = MID;
          step_nxt   = STEP0;
          lin_nxt    = {LW{1'b0}};
          retry_nxt  = {RW{1'b0}};
          dir_nxt    = NONE;
          locked_nxt = 1'b0;
          fail_nxt   = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      ARM: begin
        if (tc_s) state_nxt = WAIT;
        else      state_nxt = ARM;
      end
      WAIT: begin
        if (freq_check_done) begin
          fast_nxt  = ref_clk_is_faster;
          slow_nxt  = ref_clk_is_slower;
          state_nxt = ADJUST;
        end else if (tc_s) begin
          // Silent PFD for a whole window: the code is in range.
          state_nxt = DONE_OK;
        end else begin
          state_nxt = WAIT;
        end
      end
      ADJUST: begin
        if (fast_r == slow_r) begin
          // Contradictory or empty verdict: recheck at the same code.
          retry_nxt = retry_r + RW'(1);
          if (retry_nxt > RW'(MAX_RETRY)) state_nxt = DONE_FAIL;
          else                            state_nxt = ARM;
        end else if (step_r != ZC) begin
          if (fast_r) begin
            code_nxt = (sum_s > {1'b0, MAXC}) ? MAXC : sum_s[CODE_W-1:0];
          end else begin
            code_nxt = dif_s[CODE_W] ? ZC : dif_s[CODE_W-1:0];
          end
          step_nxt  = step_r >> 1;
          state_nxt = SETTLE;
        end else begin
          lin_nxt = lin_inc_s;
          if ((dir_r != NONE) && (mv_dir_s != dir_r)) begin
            // Verdict flipped: keep the code from before this reversal.
            state_nxt = DONE_OK;
          end else if ((fast_r && (dco_code == MAXC)) || (!fast_r && (dco_code == ZC))) begin
            state_nxt = DONE_FAIL;
          end else if (lin_inc_s > LW'(MAX_LIN)) begin
            state_nxt = DONE_FAIL;
          end else begin
            code_nxt  = fast_r ? (dco_code + ONEC) : (dco_code - ONEC);
            dir_nxt   = mv_dir_s;
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (tc_s) state_nxt = ARM;
        else      state_nxt = SETTLE;
      end
      DONE_OK: begin
        locked_nxt = 1'b1;
        state_nxt  = IDLE;
      end
      DONE_FAIL: begin
        fail_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Timer (re)load on entry to each timed state.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = {TW{1'b0}};
    if (state_nxt != state_r) begin
      case (state_nxt)
        ARM: begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TW'(ARM_CYC - 1);
        end
        WAIT: begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TW'(CHECK_TIMEOUT - 1);
        end
        SETTLE: begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TW'(SETTLE_CYC - 1);
        end
        default: begin
          tmr_load_s = 1'b0;
          tmr_val_s  = {TW{1'b0}};
        end
      endcase
    end else begin
      tmr_load_s = 1'b0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_r    <= IDLE;
      dco_code   <= MID;
      step_r     <= STEP0;
      lin_r      <= {LW{1'b0}};
      retry_r    <= {RW{1'b0}};
      dir_r      <= NONE;
      fast_r     <= 1'b0;
      slow_r     <= 1'b0;
      pfd_rst_n  <= 1'b0;
      cal_busy   <= 1'b0;
      cal_locked <= 1'b0;
      cal_fail   <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      dco_code   <= code_nxt;
      step_r     <= step_nxt;
      lin_r      <= lin_nxt;
      retry_r    <= retry_nxt;
      dir_r      <= dir_nxt;
      fast_r     <= fast_nxt;
      slow_r     <= slow_nxt;
      pfd_rst_n  <= (state_nxt == WAIT);
      cal_busy   <= (state_nxt != IDLE);
      cal_locked <= locked_nxt;
      cal_fail   <= fail_nxt;
    end
  end

`ifdef PLL_CAL_ITER_CNT_EN
  // ADJUST-entry counter, saturating, held after done.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      cal_iter <= 8'd0;
    end else if ((state_r == IDLE) && cal_start) begin
      cal_iter <= 8'd0;
    end else if ((state_r == ADJUST) && (cal_iter != 8'd255)) begin
      cal_iter <= cal_iter + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_cal_ctrl.sv
// tb_pll_cal_ctrl: directed self-checking bench for pll_cal_ctrl at default
// parameters (CODE_W=6, ARM_CYC=4, CHECK_TIMEOUT=200, SETTLE_CYC=16).
module tb_pll_cal_ctrl;

  logic       ref_clk = 1'b0;
  logic       rst = 1'b1;
  logic       cal_start = 1'b0;
  logic       freq_check_done = 1'b0;
  logic       ref_clk_is_faster = 1'b0;
  logic       ref_clk_is_slower = 1'b0;
  logic       pfd_rst_n;
  logic [5:0] dco_code;
  logic       cal_busy, cal_locked, cal_fail;
`ifdef PLL_CAL_ITER_CNT_EN
  logic [7:0] cal_iter;
`endif

  int checks = 0;
  int failures = 0;
  int n;

  pll_cal_ctrl dut (
    .ref_clk           (ref_clk),
    .rst               (rst),
    .cal_start         (cal_start),
    .freq_check_done   (freq_check_done),
    .ref_clk_is_faster (ref_clk_is_faster),
    .ref_clk_is_slower (ref_clk_is_slower),
    .pfd_rst_n         (pfd_rst_n),
    .dco_code          (dco_code),
    .cal_busy          (cal_busy),
    .cal_locked        (cal_locked),
    .cal_fail          (cal_fail)
`ifdef PLL_CAL_ITER_CNT_EN
    ,
    .cal_iter          (cal_iter)
`endif
  );

  always #5 ref_clk = ~ref_clk;

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pfd(output int cnt);
    cnt = 0;
    while (pfd_rst_n !== 1'b1 && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (cal_busy !== 1'b0 && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  // Pulse a verdict in WAIT; returns in the cycle after ADJUST.
  task automatic verdict(input logic f, input logic s);
    freq_check_done   = 1'b1;
    ref_clk_is_faster = f;
    ref_clk_is_slower = s;
    tick();
    freq_check_done   = 1'b0;
    ref_clk_is_faster = 1'b0;
    ref_clk_is_slower = 1'b0;
    tick();
  endtask

  task automatic start_cal();
    int c;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("start_busy", cal_busy, 1);
    chk("start_locked_clr", cal_locked, 0);
    chk("start_fail_clr", cal_fail, 0);
    chk("start_code_mid", dco_code, 32);
    chk("start_pfd_low", pfd_rst_n, 0);
    wait_pfd(c);
    chk("arm_len", c, 4);
  endtask

  task automatic step_to(input logic f, input logic s, input int exp_code);
    int c;
    verdict(f, s);
    chk($sformatf("code_%0d", exp_code), dco_code, exp_code);
    wait_pfd(c);
    chk("settle_arm_len", c, 20);
  endtask

  task automatic binary_to_43();
    step_to(1'b1, 1'b0, 48);
    step_to(1'b0, 1'b1, 40);
    step_to(1'b1, 1'b0, 44);
    step_to(1'b0, 1'b1, 42);
    step_to(1'b1, 1'b0, 43);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_code", dco_code, 32);
    chk("rst_pfd", pfd_rst_n, 0);
    chk("rst_busy", cal_busy, 0);
    chk("rst_locked", cal_locked, 0);
    chk("rst_fail", cal_fail, 0);
    tick();
    chk("idle_pfd", pfd_rst_n, 0);

    // Binary search then timeout lock
    start_cal();
    binary_to_43();
    wait_idle(n);
    chk("timeout_len", n, 201);
    chk("a_locked", cal_locked, 1);
    chk("a_fail", cal_fail, 0);
    chk("a_code", dco_code, 43);
    chk("a_pfd", pfd_rst_n, 0);

    // Linear oscillation
    start_cal();
    binary_to_43();
    step_to(1'b1, 1'b0, 44);
    verdict(1'b0, 1'b1);
    chk("b_done_busy", cal_busy, 1);
    tick();
    chk("b_busy", cal_busy, 0);
    chk("b_locked", cal_locked, 1);
    chk("b_fail", cal_fail, 0);
    chk("b_code", dco_code, 44);

    // Saturation fail
    start_cal();
    step_to(1'b1, 1'b0, 48);
    step_to(1'b1, 1'b0, 56);
    step_to(1'b1, 1'b0, 60);
    step_to(1'b1, 1'b0, 62);
    step_to(1'b1, 1'b0, 63);
    verdict(1'b1, 1'b0);
    tick();
    chk("c_busy", cal_busy, 0);
    chk("c_fail", cal_fail, 1);
    chk("c_locked", cal_locked, 0);
    chk("c_code", dco_code, 63);

    // Invalid verdicts; start in the DONE cycle is ignored
    start_cal();
    for (int i = 0; i < 3; i++) begin
      verdict(1'b1, 1'b1);
      chk("d_code_hold", dco_code, 32);
      chk("d_not_failed", cal_fail, 0);
      wait_pfd(n);
      chk("d_rearm_len", n, 4);
    end
    verdict(1'b1, 1'b1);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("d_fail", cal_fail, 1);
    chk("d_code", dco_code, 32);
    tick();
    chk("d_done_start_ignored", cal_busy, 0);
    chk("d_fail_held", cal_fail, 1);

    // Reset mid-WAIT
    start_cal();
    step_to(1'b1, 1'b0, 48);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("e_code", dco_code, 32);
    chk("e_pfd", pfd_rst_n, 0);
    chk("e_busy", cal_busy, 0);
    chk("e_locked", cal_locked, 0);
    chk("e_fail", cal_fail, 0);
    tick();
    chk("e_stay_idle", cal_busy, 0);

    // Start pulses while busy are ignored
    start_cal();
    verdict(1'b1, 1'b0);
    chk("f_code48", dco_code, 48);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    wait_pfd(n);
    chk("f_settle_len", n, 19);
    chk("f_code_kept", dco_code, 48);
    step_to(1'b0, 1'b1, 40);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("f_pfd_still_high", pfd_rst_n, 1);
    wait_idle(n);
    chk("f_timeout_len", n, 200);
    chk("f_locked", cal_locked, 1);
    chk("f_code", dco_code, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
